// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg: register offsets, field positions and config types shared by the UART APB interfaces.
package uart_apb_pkg;
  localparam logic [2:0] OFF_RXCTRL = 3'd0;
  localparam logic [2:0] OFF_RXSTAT = 3'd1;
  localparam logic [2:0] OFF_RXDATA = 3'd2;
  localparam logic [2:0] OFF_IER    = 3'd3;
  localparam logic [2:0] OFF_ISR    = 3'd4;
  localparam int CTRL_W   = 5;
  localparam int ISR_W    = 6;
  localparam int STICKY_W = 4;
  localparam int CTRL_EN  = 0;
  localparam int ISR_NE   = 0;
  localparam int ISR_RXF  = 1;
  localparam int ISR_OV   = 2;
  localparam int ISR_PE   = 3;
  localparam int ISR_FE   = 4;
  localparam int ISR_UDF  = 5;
  typedef struct packed {
    logic [1:0] rxt;
    logic       ep;
    logic       d9;
  } rx_cfg_t;
  function automatic logic off_mapped(input logic [2:0] off);
    return off <= OFF_ISR;
  endfunction
endpackage

// File: rtl/uart_rx_apb_if_if.sv
// uart_rx_apb_if_if: APB3 bus bundle with master/slave views.
interface uart_rx_apb_if_if #(parameter int ADDR_W = 12, parameter int DATA_W = 32);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
endinterface

// File: rtl/uart_rx_cfg_shadow.sv
// uart_rx_cfg_shadow: holds written d9/ep/rxt and applies them only between frames when enabled.
module uart_rx_cfg_shadow
  import uart_apb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    wr,
  input  logic    en_cur,
  input  logic    en_new,
  input  logic    rx_busy,
  input  rx_cfg_t wcfg,
  output rx_cfg_t shadow,
  output rx_cfg_t cfg
);
  rx_cfg_t shadow_q, shadow_d, cfg_q, cfg_d;
  logic    pend_q, pend_d, defer;
  always_comb begin
    defer    = rx_busy & en_cur & en_new;
    shadow_d = wr ? wcfg : shadow_q;
    pend_d   = wr ? defer : pend_q & rx_busy;
    cfg_d    = wr ? (defer ? cfg_q : wcfg) : (pend_q & ~rx_busy ? shadow_q : cfg_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      cfg_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      pend_q   <= pend_d;
    end
  end
  assign shadow = shadow_q;
  assign cfg    = cfg_q;
endmodule

// File: rtl/uart_rx_apb_if.sv
// uart_rx_apb_if: APB3 register slave for the UART receiver (config, status, data pop, sticky interrupts).
module uart_rx_apb_if
  import uart_apb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  pclk,
  input  logic                  preset,
  uart_rx_apb_if_if.slave       apb,
  output logic                  irq,
  output logic                  ctrl_en,
  output logic                  ctrl_d9,
  output logic                  ctrl_ep,
  output logic [1:0]            ctrl_rxt,
  output logic                  ctrl_data_rd,
  input  logic                  rx_ne,
  input  logic                  rx_busy,
  input  logic                  rx_rxf,
  input  logic                  rx_ov,
  input  logic                  rx_pe,
  input  logic                  rx_fe,
  input  logic [7:0]            rx_data
);
  logic [2:0]          off;
  logic                acc, err, wr, rd, ctrl_wr;
  logic                en_q, en_d, ov_prev_q, irq_q, irq_d;
  logic [ISR_W-1:0]    ier_q, ier_d, isr;
  logic [STICKY_W-1:0] sticky_q, sticky_d, set, w1c;
  logic [9:0]          rdata;
  logic                unused_bits;
  rx_cfg_t             shadow, cfg;
  always_comb begin
    off          = apb.paddr[4:2];
    acc          = apb.psel & apb.penable & ~preset;
    err          = (apb.paddr[ADDR_W-1:5] != '0) | ~off_mapped(off)
                 | (apb.pwrite & (off == OFF_RXSTAT | off == OFF_RXDATA));
    wr           = acc & ~err & apb.pwrite;
    rd           = acc & ~err & ~apb.pwrite;
    ctrl_wr      = wr & off == OFF_RXCTRL;
    ctrl_data_rd = rd & off == OFF_RXDATA & rx_ne;
    isr          = {sticky_q, rx_rxf, rx_ne};
    rdata        = off == OFF_RXCTRL ? {5'b0, shadow, en_q}
                 : off == OFF_RXSTAT ? {4'b0, rx_fe, rx_pe, rx_ov, rx_rxf, rx_busy, rx_ne}
                 : off == OFF_RXDATA ? (rx_ne ? {rx_fe, rx_pe, rx_data} : 10'b0)
                 : off == OFF_IER    ? {4'b0, ier_q}
                 : {4'b0, isr};
    apb.prdata   = rd ? {{(DATA_W-10){1'b0}}, rdata} : '0;
    apb.pready   = apb.psel & apb.penable;
    apb.pslverr  = acc & err;
    en_d         = ctrl_wr ? apb.pwdata[CTRL_EN] : en_q;
    ier_d        = wr & off == OFF_IER ? apb.pwdata[ISR_W-1:0] : ier_q;
    w1c          = wr & off == OFF_ISR ? apb.pwdata[ISR_UDF:ISR_OV] : '0;
    // a new event in the same cycle as its W1C must survive
    set          = {rd & off == OFF_RXDATA & ~rx_ne, ctrl_data_rd & rx_fe,
                    ctrl_data_rd & rx_pe, rx_ov & ~ov_prev_q};
    sticky_d     = (sticky_q & ~w1c) | set;
    irq_d        = |(isr & ier_q);
    unused_bits  = ^{apb.pwdata[DATA_W-1:ISR_W], apb.paddr[1:0]};
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      en_q      <= 1'b0;
      ier_q     <= '0;
      sticky_q  <= '0;
      ov_prev_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      ier_q     <= ier_d;
      sticky_q  <= sticky_d;
      ov_prev_q <= rx_ov;
      irq_q     <= irq_d;
    end
  end
  uart_rx_cfg_shadow u_shadow (
    .clk     (pclk),
    .rst     (preset),
    .wr      (ctrl_wr),
    .en_cur  (en_q),
    .en_new  (apb.pwdata[CTRL_EN]),
    .rx_busy (rx_busy),
    .wcfg    (rx_cfg_t'(apb.pwdata[CTRL_W-1:1])),
    .shadow  (shadow),
    .cfg     (cfg)
  );
  assign ctrl_en  = en_q;
  assign ctrl_d9  = cfg.d9;
  assign ctrl_ep  = cfg.ep;
  assign ctrl_rxt = cfg.rxt;
  assign irq      = irq_q;
endmodule

// File: tb/tb_uart_rx_apb_if.sv
// tb_uart_rx_apb_if: scoreboard bench with directed and random APB traffic against a register-level model.
module tb_uart_rx_apb_if;
  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;
  uart_rx_apb_if_if #(.ADDR_W(12), .DATA_W(32)) apb ();
  logic irq, ctrl_en, ctrl_d9, ctrl_ep, ctrl_data_rd;
  logic [1:0] ctrl_rxt;
  logic rx_ne = 0, rx_busy = 0, rx_rxf = 0, rx_ov = 0, rx_pe = 0, rx_fe = 0;
  logic [7:0] rx_data = 8'h00;
  uart_rx_apb_if #(.ADDR_W(12), .DATA_W(32)) dut (
    .pclk(pclk), .preset(preset), .apb(apb), .irq(irq), .ctrl_en(ctrl_en), .ctrl_d9(ctrl_d9),
    .ctrl_ep(ctrl_ep), .ctrl_rxt(ctrl_rxt), .ctrl_data_rd(ctrl_data_rd), .rx_ne(rx_ne),
    .rx_busy(rx_busy), .rx_rxf(rx_rxf), .rx_ov(rx_ov), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_data(rx_data)
  );
  typedef struct {
    logic        rd;
    logic [11:0] addr;
    logic [31:0] data;
    logic        err;
    logic        pop;
  } exp_t;
  exp_t exp_q[$];
  exp_t me;
  int total = 0, bad = 0, pops_seen = 0, m_pops = 0;
  logic [4:0] m_ctl = 0;
  logic [3:0] m_out = 0, m_st = 0;
  logic [5:0] m_ier = 0;
  logic m_en = 0, m_pend = 0, m_ovp = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] model_read(input logic [2:0] i);
    case (i)
      3'd0: return {27'b0, m_ctl};
      3'd1: return {26'b0, rx_fe, rx_pe, rx_ov, rx_rxf, rx_busy, rx_ne};
      3'd2: return rx_ne ? {22'b0, rx_fe, rx_pe, rx_data} : 32'b0;
      3'd3: return {26'b0, m_ier};
      default: return {26'b0, m_st, rx_rxf, rx_ne};
    endcase
  endfunction
  always @(negedge pclk) begin
    if (ctrl_data_rd) pops_seen++;
    if (apb.psel && apb.penable && !preset) begin
      if (exp_q.size() == 0) chk("unexpected_xfer", 32'd1, 32'd0);
      else begin
        me = exp_q.pop_front();
        chk($sformatf("pslverr@%h", me.addr), {31'b0, apb.pslverr}, {31'b0, me.err});
        chk($sformatf("pready@%h", me.addr), {31'b0, apb.pready}, 32'd1);
        chk($sformatf("data_rd@%h", me.addr), {31'b0, ctrl_data_rd}, {31'b0, me.pop});
        if (me.rd) chk($sformatf("prdata@%h", me.addr), apb.prdata, me.data);
      end
    end
  end
  task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] d, input logic ov_rise = 1'b0);
    exp_t e;
    logic [2:0] i;
    logic defer;
    i = a[4:2];
    e.addr = a;
    e.err = (a[11:5] != 0) || i > 3'd4 || (w && (i == 3'd1 || i == 3'd2));
    e.rd = !w;
    e.pop = !w && !e.err && i == 3'd2 && rx_ne;
    e.data = (!w && !e.err) ? model_read(i) : 32'b0;
    exp_q.push_back(e);
    @(posedge pclk); #1;
    apb.psel = 1; apb.penable = 0; apb.pwrite = w; apb.paddr = a; apb.pwdata = d;
    @(posedge pclk); #1;
    apb.penable = 1;
    if (ov_rise) rx_ov = 1;
    @(posedge pclk); #1;
    apb.psel = 0; apb.penable = 0;
    if (!e.err && w) begin
      if (i == 3'd0) begin
        defer = rx_busy && m_en && d[0];
        m_ctl = d[4:0];
        if (!defer) m_out = d[4:1];
        m_pend = defer;
        m_en = d[0];
      end
      if (i == 3'd3) m_ier = d[5:0];
      if (i == 3'd4) m_st = m_st & ~d[5:2];
    end
    if (e.pop) begin
      m_pops++;
      if (rx_fe) m_st[2] = 1;
      if (rx_pe) m_st[1] = 1;
    end
    if (!e.err && !w && i == 3'd2 && !rx_ne) m_st[3] = 1;
    if (ov_rise && !m_ovp) m_st[0] = 1;
    m_ovp = rx_ov;
  endtask
  task automatic set_rx(input logic ne, busy, rxf, ov, pe, fe, input logic [7:0] dat);
    @(posedge pclk); #1;
    rx_ne = ne; rx_busy = busy; rx_rxf = rxf; rx_ov = ov; rx_pe = pe; rx_fe = fe; rx_data = dat;
    if (ov && !m_ovp) m_st[0] = 1;
    m_ovp = ov;
    if (m_pend && !busy) begin
      m_out = m_ctl[4:1];
      m_pend = 0;
    end
    @(posedge pclk); #1;
  endtask
  task automatic check_state(input string tag);
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk({tag, "_en"}, {31'b0, ctrl_en}, {31'b0, m_en});
    chk({tag, "_cfg"}, {28'b0, ctrl_rxt, ctrl_ep, ctrl_d9}, {28'b0, m_out});
    chk({tag, "_irq"}, {31'b0, irq}, {31'b0, |({m_st, rx_rxf, rx_ne} & m_ier)});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    logic [11:0] alist [10];
    alist = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'h01C, 12'h020, 12'h100};
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = '0; apb.pwdata = '0;
    repeat (3) @(posedge pclk);
    #1 preset = 0;
    @(negedge pclk);
    chk("rst_pslverr", {31'b0, apb.pslverr}, 32'd0);
    chk("rst_data_rd", {31'b0, ctrl_data_rd}, 32'd0);
    check_state("reset");
    xfer(0, 12'h000, 0); xfer(0, 12'h00C, 0); xfer(0, 12'h010, 0);
    xfer(1, 12'h000, 32'h1F);
    check_state("cfg_all");
    xfer(0, 12'h000, 0);
    set_rx(0, 1, 0, 0, 0, 0, 8'h00);
    xfer(1, 12'h000, 32'h01);
    check_state("busy_hold");
    xfer(0, 12'h000, 0);
    set_rx(0, 0, 0, 0, 0, 0, 8'h00);
    check_state("busy_fall");
    set_rx(1, 0, 0, 0, 0, 1, 8'hA5);
    xfer(1, 12'h00C, 32'h10);
    xfer(0, 12'h008, 0);
    check_state("fe_irq");
    xfer(0, 12'h010, 0);
    xfer(1, 12'h010, 32'h10);
    check_state("fe_clr");
    set_rx(0, 0, 0, 0, 0, 0, 8'h00);
    xfer(1, 12'h00C, 32'h20);
    xfer(0, 12'h008, 0);
    check_state("udf_irq");
    xfer(0, 12'h014, 0);
    xfer(1, 12'h004, 32'hFF);
    xfer(1, 12'h008, 32'hFF);
    xfer(1, 12'h020, 32'h1E);
    xfer(0, 12'h000, 0); xfer(0, 12'h00C, 0);
    check_state("err_nochange");
    xfer(1, 12'h010, 32'h04, 1'b1);
    xfer(0, 12'h010, 0);
    check_state("set_wins");
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(3) == 0)
        set_rx($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
               $urandom_range(1), $urandom_range(1), 8'($urandom));
      xfer($urandom_range(1), alist[$urandom_range(9)], ($urandom_range(1) ? 32'($urandom) : 32'($urandom_range(63))));
      check_state("rand");
    end
    set_rx(1, 0, 0, 0, 0, 0, 8'h3C);
    @(posedge pclk); #1;
    apb.psel = 1; apb.penable = 0; apb.pwrite = 0; apb.paddr = 12'h008;
    @(posedge pclk); #1;
    apb.penable = 1; preset = 1;
    @(negedge pclk);
    chk("midrst_no_pop", {31'b0, ctrl_data_rd}, 32'd0);
    chk("midrst_pslverr", {31'b0, apb.pslverr}, 32'd0);
    chk("midrst_prdata", apb.prdata, 32'd0);
    @(posedge pclk); #1;
    apb.psel = 0; apb.penable = 0;
    @(posedge pclk); #1;
    preset = 0;
    m_ctl = 0; m_out = 0; m_st = 0; m_ier = 0; m_en = 0; m_pend = 0; m_ovp = 0;
    check_state("after_rst");
    xfer(0, 12'h000, 0); xfer(0, 12'h010, 0); xfer(0, 12'h00C, 0);
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("pop_count", pops_seen, m_pops);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
